// File: rtl/periph_reg_fabric_pkg.sv
// Shared types and constants for the peripheral register fabric.
package periph_reg_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } fab_state_e;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    localparam int CTRL_OFS   = 0;
    localparam int STATUS_OFS = 1;

    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_IDX_LSB = 8;
    localparam int STAT_FLD_W   = 8;

endpackage

// File: rtl/pfab_guard_timer.sv
// Loadable down-counter that stops at zero; used for the access
// timeout and for the pad guard window.
module pfab_guard_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/periph_reg_fabric.sv
// Register-bus fabric: decodes one host port onto NUM_SLV slaves plus an
// internal CTRL/STATUS space, with access timeout and guarded pin select.
module periph_reg_fabric
    import periph_reg_fabric_pkg::*;
#(
    parameter int NUM_SLV   = 3,
    parameter int SLV_AW    = 6,
    parameter int DW        = 32,
    parameter int TMO_CYC   = 255,
    parameter int GUARD_CYC = 16,
    localparam int SEL_W    = $clog2(NUM_SLV + 1),
    localparam int AW       = SEL_W + SLV_AW
) (
    input  logic                  app_clk,
    input  logic                  app_rst,
    input  logic                  reg_cs,
    input  logic                  reg_wr,
    input  logic [AW-1:0]         reg_addr,
    input  logic [DW-1:0]         reg_wdata,
    input  logic [DW/8-1:0]       reg_be,
    output logic [DW-1:0]         reg_rdata,
    output logic                  reg_ack,
    output logic                  reg_err,
    output logic [NUM_SLV-1:0]    slv_cs,
    output logic                  slv_wr,
    output logic [SLV_AW-1:0]     slv_addr,
    output logic [DW-1:0]         slv_wdata,
    output logic [DW/8-1:0]       slv_be,
    input  logic [NUM_SLV*DW-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]    slv_ack,
    output logic [SEL_W-1:0]      pin_sel,
    output logic                  pin_guard
);

    localparam int WOFS_W = SLV_AW - 2;
    localparam logic [DW-1:0]    ERR_D   = DW'(ERR_DATA);
    localparam logic [SEL_W-1:0] INT_IDX = SEL_W'(NUM_SLV);

    fab_state_e state_q, state_d;

    logic [NUM_SLV-1:0] slv_cs_q, slv_cs_d;
    logic [SEL_W-1:0]   idx_q;
    logic               slv_wr_q;
    logic [SLV_AW-1:0]  slv_addr_q;
    logic [DW-1:0]      slv_wdata_q;
    logic [DW/8-1:0]    slv_be_q;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   pin_sel_q;
    logic [7:0]         tmo_cnt_q, last_idx_q;

    logic               latch, tmo_load, tmo_en, tmo_zero, tmo_hit;
    logic               ctrl_wr, stat_clr, grd_load, grd_zero;
    logic [SEL_W-1:0]   req_idx;
    logic [WOFS_W-1:0]  req_wofs;
    logic [NUM_SLV-1:0] req_onehot;
    logic               ack_hit;
    logic [DW-1:0]      ack_rdata, int_rdata;

    assign req_idx  = reg_addr[AW-1:SLV_AW];
    assign req_wofs = reg_addr[SLV_AW-1:2];

    // Only the ack line of the slave being accessed is honoured.
    always_comb begin
        req_onehot = '0;
        ack_hit    = 1'b0;
        ack_rdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (req_idx == SEL_W'(i)) begin
                req_onehot[i] = 1'b1;
            end
            if (idx_q == SEL_W'(i)) begin
                ack_hit   = slv_ack[i];
                ack_rdata = slv_rdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        int_rdata = '0;
        if (req_wofs == WOFS_W'(CTRL_OFS)) begin
            int_rdata[SEL_W-1:0] = pin_sel_q;
        end else if (req_wofs == WOFS_W'(STATUS_OFS)) begin
            int_rdata[STAT_CNT_LSB +: STAT_FLD_W] = tmo_cnt_q;
            int_rdata[STAT_IDX_LSB +: STAT_FLD_W] = last_idx_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        slv_cs_d = slv_cs_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        latch    = 1'b0;
        tmo_load = 1'b0;
        tmo_en   = 1'b0;
        tmo_hit  = 1'b0;
        ctrl_wr  = 1'b0;
        stat_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (reg_cs) begin
                    if (req_idx < INT_IDX) begin
                        latch    = 1'b1;
                        tmo_load = 1'b1;
                        slv_cs_d = req_onehot;
                        state_d  = ST_ACCESS;
                    end else if (req_idx == INT_IDX) begin
                        rdata_d = int_rdata;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                        if (reg_wr) begin
                            ctrl_wr  = (req_wofs == WOFS_W'(CTRL_OFS)) && reg_be[0];
                            stat_clr = (req_wofs == WOFS_W'(STATUS_OFS));
                        end
                    end else begin
                        rdata_d = ERR_D;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                tmo_en = 1'b1;
                if (ack_hit) begin
                    slv_cs_d = '0;
                    rdata_d  = ack_rdata;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (tmo_zero) begin
                    slv_cs_d = '0;
                    rdata_d  = ERR_D;
                    err_d    = 1'b1;
                    tmo_hit  = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                slv_cs_d = '0;
            end
        endcase
    end

    // Rewriting the current pin function must not disturb the pads.
    assign grd_load = ctrl_wr && (reg_wdata[SEL_W-1:0] != pin_sel_q);

    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            state_q     <= ST_IDLE;
            slv_cs_q    <= '0;
            idx_q       <= '0;
            slv_wr_q    <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            slv_be_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            pin_sel_q   <= '0;
            tmo_cnt_q   <= '0;
            last_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            slv_cs_q <= slv_cs_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            if (latch) begin
                idx_q       <= req_idx;
                slv_wr_q    <= reg_wr;
                slv_addr_q  <= reg_addr[SLV_AW-1:0];
                slv_wdata_q <= reg_wdata;
                slv_be_q    <= reg_be;
            end
            if (grd_load) begin
                pin_sel_q <= reg_wdata[SEL_W-1:0];
            end
            if (stat_clr) begin
                tmo_cnt_q  <= '0;
                last_idx_q <= '0;
            end else if (tmo_hit) begin
                if (tmo_cnt_q != 8'hFF) begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                end
                last_idx_q <= 8'(idx_q);
            end
        end
    end

    pfab_guard_timer #(.W(16)) u_tmo (
        .clk_i      (app_clk),
        .rst_i      (app_rst),
        .load_i     (tmo_load),
        .load_val_i (16'(TMO_CYC - 1)),
        .en_i       (tmo_en),
        .zero_o     (tmo_zero)
    );

    pfab_guard_timer #(.W(8)) u_grd (
        .clk_i      (app_clk),
        .rst_i      (app_rst),
        .load_i     (grd_load),
        .load_val_i (8'(GUARD_CYC)),
        .en_i       (1'b1),
        .zero_o     (grd_zero)
    );

    assign reg_rdata = rdata_q;
    assign reg_err   = err_q;
    assign reg_ack   = (state_q == ST_RESP);
    assign slv_cs    = slv_cs_q;
    assign slv_wr    = slv_wr_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;
    assign slv_be    = slv_be_q;
    assign pin_sel   = pin_sel_q;
    assign pin_guard = !grd_zero;

endmodule

// File: doc/periph_reg_fabric.md
Name: periph_reg_fabric

Overview:
Parametrised register-bus fabric that replaces a fixed three-way combinational response mux for pin-shared serial peripherals. Decodes one host register port into NUM_SLV slave ports and registers the slave response. Adds a per-access timeout that returns an error response, internal control/status registers, and a guarded pad-function select. Sits between the system register bridge and the UART/I2C/USB-class cores that share top-level pins.

Parameters:
NUM_SLV, 3, number of slave peripherals; slave index NUM_SLV is internal register space
SLV_AW, 6, per-slave byte-address width
DW, 32, data width (multiple of 8)
TMO_CYC, 255, cycles in ACCESS without slv_ack before timeout (1..65535)
GUARD_CYC, 16, pad-idle cycles after a pin_sel change (1..255)
Derived, not overridable: SEL_W = $clog2(NUM_SLV+1); AW = SEL_W+SLV_AW.

Ports:
app_clk  in  1  fabric clock
app_rst  in  1  asynchronous, active-high reset
reg_cs  in  1  host request; held until reg_ack, dropped the cycle after
reg_wr  in  1  1 = write
reg_addr  in  AW  [AW-1:SLV_AW] = slave index, [SLV_AW-1:0] = offset
reg_wdata  in  DW  write data
reg_be  in  DW/8  byte enables
reg_rdata  out  DW  read data, valid with reg_ack
reg_ack  out  1  single-cycle response pulse
reg_err  out  1  error qualifier, valid with reg_ack
slv_cs  out  NUM_SLV  one-hot slave select
slv_wr  out  1  registered copy of reg_wr
slv_addr  out  SLV_AW  registered offset
slv_wdata  out  DW  registered write data
slv_be  out  DW/8  registered byte enables
slv_rdata  in  NUM_SLV*DW  slave i read data in bits [i*DW +: DW]
slv_ack  in  NUM_SLV  slave acknowledges
pin_sel  out  SEL_W  active pad function (slave index)
pin_guard  out  1  1 = pads must be driven idle/tristate

Behaviour:
- Reset (async, app_rst=1): FSM=IDLE. slv_cs=0. reg_ack=0. reg_err=0. reg_rdata=0. All slv_* outputs 0. pin_sel=0. pin_guard=0. Timeout counter and status register 0. Asserting reset mid-access drops slv_cs immediately, and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, reg_cs=1, index<NUM_SLV: latch addr/wdata/be/wr. Assert slv_cs[index] next cycle. Go to ACCESS. Clear the timeout counter.
- IDLE, index==NUM_SLV (internal): perform the register read/write. Go to RESP. reg_ack is asserted in the next cycle.
- IDLE, index>NUM_SLV (unmapped): go to RESP with err=1 and rdata=ERR_DATA.
- ACCESS, slv_ack[index]=1: capture slv_rdata slice. Drop slv_cs the same edge. Go to RESP with err=0. Slave acks on other lines are ignored.
- ACCESS, counter==TMO_CYC-1 with no ack: drop slv_cs. Go to RESP with err=1 and rdata=ERR_DATA. Status timeout count increments, saturating at 255. last_err_idx is set to the index.
- RESP: reg_ack=1 for exactly one cycle. reg_rdata and reg_err are held until the next ack. Go to IDLE.
- Latency: zero-wait slave gives request at cycle 0, slv_cs at cycle 1, reg_ack at cycle 2. Internal register: reg_ack at cycle 1.
- The host must drop reg_cs the cycle after reg_ack. reg_cs=1 seen in IDLE is always a new request.
- Internal registers (word offsets, offset[SLV_AW-1:2]):
  - 0 CTRL: [SEL_W-1:0] pin_sel, R/W.
  - 1 STATUS: [7:0] timeout count, [15:8] last_err_idx, RO. Any write clears both fields.
  - Other offsets: read 0, write ignored, err=0.
- CTRL write with reg_be[0]=0 is ignored.
- pin_sel change: writing a value different from the current one updates pin_sel at the RESP edge. pin_guard=1 for GUARD_CYC cycles starting that cycle.
- A pin_sel rewrite during guard restarts the guard count. Writing an equal value has no effect. Slave accesses proceed during guard.
- Width: slot index compare is unsigned over SEL_W bits. ERR_DATA = 32'hDEAD_BEEF truncated or zero-extended to DW.

Decomposition:
- Package periph_reg_fabric_pkg: FSM state enum, ERR_DATA, internal offsets CTRL_OFS=0 and STATUS_OFS=1, status field positions.
- One sub-module, pfab_guard_timer: loadable down-counter, also instantiated for the access timeout, with a load value port and a zero flag.

Test Plan:
- Read slave 1, offset 0x04; slave 1 acks the cycle slv_cs rises with 32'h1234_5678 -> slv_cs=3'b010 at cycle 1, reg_ack at cycle 2, reg_rdata=32'h1234_5678, reg_err=0.
- Write slave 0 with slave ack delayed 5 cycles -> slv_wdata/slv_be stable throughout, reg_ack exactly 1 cycle after slv_ack, slv_cs dropped on the ack edge.
- Access slave 2 that never acks, TMO_CYC=8 -> slv_cs high 8 cycles, reg_ack with reg_err=1, rdata=32'hDEADBEEF, STATUS reads 32'h0000_0201.
- Access index 3 (NUM_SLV=3) writing CTRL=2 -> ack at cycle 1, pin_sel=2, pin_guard high 16 cycles. Rewrite 2 -> no guard. Write 1 mid-guard -> guard restarts.
- Unmapped index 5 (SEL_W=3, rdata 0 until error) -> reg_ack, reg_err=1, no slv_cs pulse. STATUS write clears to 0.
- Assert app_rst while in ACCESS -> slv_cs=0 and all outputs 0 asynchronously. No reg_ack after release. Next request serviced normally.
